// File: rtl/n2_tlb_ctl_pkg.sv
// Shared types and constants for the TLB control sequencer/arbiter.
// The optional perf counters are enabled with N2_TLB_CTL_PERF_EN.
package n2_tlb_ctl_pkg;

    localparam int IDX_W            = 7;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int PERF_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD       = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DMP      = 3'd4,
        ST_DMP_WAIT = 3'd5
    } tlb_state_e;

    typedef enum logic [1:0] {
        DMP_PAGE = 2'd0,
        DMP_CTX  = 2'd1,
        DMP_ALL  = 2'd2,
        DMP_REAL = 2'd3
    } dmp_type_e;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        return (val == {PERF_W{1'b1}}) ? val : val + PERF_W'(1);
    endfunction

endpackage

// File: rtl/n2_tlb_ctl_perf.sv
// Saturating CAM lookup / hit / multi-hit counters (N2_TLB_CTL_PERF_EN builds only).
module n2_tlb_ctl_perf
    import n2_tlb_ctl_pkg::*;
(
    input  logic              l2clk,
    input  logic              reset,
    input  logic              cam_vld,
    input  logic              cam_hit,
    input  logic              cam_mhit,
    output logic [PERF_W-1:0] cam_lookup_cnt,
    output logic [PERF_W-1:0] cam_hit_cnt,
    output logic [PERF_W-1:0] cam_mhit_cnt
);

    logic cam_vld_d_r;

    // Array hit flags are valid the cycle after the CAM strobe.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            cam_vld_d_r    <= 1'b0;
            cam_lookup_cnt <= '0;
            cam_hit_cnt    <= '0;
            cam_mhit_cnt   <= '0;
        end else begin
            cam_vld_d_r <= cam_vld;
            if (cam_vld) cam_lookup_cnt <= sat_inc(cam_lookup_cnt);
            else         cam_lookup_cnt <= cam_lookup_cnt;
            if (cam_vld_d_r && cam_hit) cam_hit_cnt <= sat_inc(cam_hit_cnt);
            else                        cam_hit_cnt <= cam_hit_cnt;
            if (cam_vld_d_r && cam_mhit) cam_mhit_cnt <= sat_inc(cam_mhit_cnt);
            else                         cam_mhit_cnt <= cam_mhit_cnt;
        end
    end

endmodule

// File: rtl/n2_tlb_ctl_arb.sv
// TLB array port sequencer: arbitrates CAM lookup, fill, ASI and demap onto one port.
// Define N2_TLB_CTL_PERF_EN to add the saturating lookup/hit counters.
module n2_tlb_ctl_arb
    import n2_tlb_ctl_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic             l2clk,
    input  logic             reset,
    input  logic             cam_req,
    output logic             cam_stall,
    input  logic             fill_req,
    input  logic             fill_index_vld,
    input  logic [IDX_W-1:0] fill_index,
    output logic             fill_gnt,
    input  logic             asi_req,
    input  logic             asi_rd,
    input  logic [IDX_W-1:0] asi_index,
    output logic             asi_gnt,
    output logic             asi_rd_done,
    input  logic             dmp_req,
    input  logic [1:0]       dmp_type,
    output logic             dmp_gnt,
    output logic             dmp_done,
    input  logic             tlb_cam_hit,
    input  logic             tlb_cam_mhit,
    output logic             tlb_cam_vld,
    output logic             tlb_wr_vld,
    output logic             tlb_rd_vld,
    output logic [IDX_W-1:0] tlb_rw_index,
    output logic             tlb_rw_index_vld,
    output logic             tlb_demap,
    output logic             tlb_demap_context,
    output logic             tlb_demap_all,
    output logic             tlb_demap_real,
    output logic [IDX_W-1:0] repl_ptr,
    output logic             busy
`ifdef N2_TLB_CTL_PERF_EN
    ,
    output logic [PERF_W-1:0] cam_lookup_cnt,
    output logic [PERF_W-1:0] cam_hit_cnt,
    output logic [PERF_W-1:0] cam_mhit_cnt
`endif
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    tlb_state_e       state_r, state_nxt_s;
    dmp_type_e        dmp_type_r, dmp_type_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r, starve_nxt_s;
    logic [IDX_W-1:0] rw_index_r, rw_index_nxt_s;
    logic [IDX_W-1:0] repl_ptr_r, repl_nxt_s;
    logic             repl_used_r, repl_used_nxt_s;
    logic             maint_pend_s, sel_maint_s, grant_s;

    assign maint_pend_s = fill_req | asi_req | dmp_req;
    assign sel_maint_s  = maint_pend_s & (~cam_req | (starve_cnt_r == STARVE_MAX));
    assign grant_s      = fill_gnt | asi_gnt | dmp_gnt;
    assign tlb_rw_index = rw_index_r;
    assign repl_ptr     = repl_ptr_r;
    assign busy         = (state_r != ST_IDLE);

    // Next-state decode and array strobes; reset forces everything quiet and stalls lookups.
    always_comb begin
        state_nxt_s       = state_r;
        dmp_type_nxt_s    = dmp_type_r;
        rw_index_nxt_s    = rw_index_r;
        repl_used_nxt_s   = repl_used_r;
        repl_nxt_s        = repl_ptr_r;
        cam_stall         = cam_req;
        fill_gnt          = 1'b0;
        asi_gnt           = 1'b0;
        asi_rd_done       = 1'b0;
        dmp_gnt           = 1'b0;
        dmp_done          = 1'b0;
        tlb_cam_vld       = 1'b0;
        tlb_wr_vld        = 1'b0;
        tlb_rd_vld        = 1'b0;
        tlb_rw_index_vld  = 1'b0;
        tlb_demap         = 1'b0;
        tlb_demap_context = 1'b0;
        tlb_demap_all     = 1'b0;
        tlb_demap_real    = 1'b0;
        if (reset) begin
            cam_stall   = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_maint_s) begin
                        cam_stall = 1'b1;
                        if (dmp_req) begin
                            dmp_gnt        = 1'b1;
                            dmp_type_nxt_s = dmp_type_e'(dmp_type);
                            state_nxt_s    = ST_DMP;
                        end else if (fill_req) begin
                            fill_gnt        = 1'b1;
                            rw_index_nxt_s  = fill_index_vld ? fill_index : repl_ptr_r;
                            repl_used_nxt_s = ~fill_index_vld;
                            state_nxt_s     = ST_WR;
                        end else begin
                            asi_gnt         = 1'b1;
                            rw_index_nxt_s  = asi_index;
                            repl_used_nxt_s = 1'b0;
                            state_nxt_s     = asi_rd ? ST_RD : ST_WR;
                        end
                    end else if (cam_req) begin
                        tlb_cam_vld = 1'b1;
                        cam_stall   = 1'b0;
                    end else begin
                        cam_stall = 1'b0;
                    end
                end
                ST_WR: begin
                    tlb_wr_vld       = 1'b1;
                    tlb_rw_index_vld = 1'b1;
                    if (repl_used_r) repl_nxt_s = repl_ptr_r + IDX_W'(1);
                    else             repl_nxt_s = repl_ptr_r;
                    state_nxt_s      = ST_IDLE;
                end
                ST_RD: begin
                    tlb_rd_vld       = 1'b1;
                    tlb_rw_index_vld = 1'b1;
                    state_nxt_s      = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    asi_rd_done = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_DMP: begin
                    tlb_demap         = 1'b1;
                    tlb_demap_context = (dmp_type_r == DMP_CTX);
                    tlb_demap_all     = (dmp_type_r == DMP_ALL);
                    tlb_demap_real    = (dmp_type_r == DMP_REAL);
                    state_nxt_s       = ST_DMP_WAIT;
                end
                ST_DMP_WAIT: begin
                    dmp_done    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Anti-starvation count of lookups issued ahead of a waiting maintenance request.
    always_comb begin
        if (!maint_pend_s || grant_s) begin
            starve_nxt_s = '0;
        end else if (tlb_cam_vld && (starve_cnt_r != STARVE_MAX)) begin
            starve_nxt_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // State, captured op parameters and replacement pointer.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            dmp_type_r   <= DMP_PAGE;
            starve_cnt_r <= '0;
            rw_index_r   <= '0;
            repl_ptr_r   <= '0;
            repl_used_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dmp_type_r   <= dmp_type_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            rw_index_r   <= rw_index_nxt_s;
            repl_ptr_r   <= repl_nxt_s;
            repl_used_r  <= repl_used_nxt_s;
        end
    end

`ifdef N2_TLB_CTL_PERF_EN
    n2_tlb_ctl_perf u_perf (
        .l2clk          (l2clk),
        .reset          (reset),
        .cam_vld        (tlb_cam_vld),
        .cam_hit        (tlb_cam_hit),
        .cam_mhit       (tlb_cam_mhit),
        .cam_lookup_cnt (cam_lookup_cnt),
        .cam_hit_cnt    (cam_hit_cnt),
        .cam_mhit_cnt   (cam_mhit_cnt)
    );
`else
    logic unused_hit_s;
    assign unused_hit_s = tlb_cam_hit ^ tlb_cam_mhit;
`endif

endmodule

// File: tb/tb_n2_tlb_ctl_arb.sv
// Directed bench for n2_tlb_ctl_arb: default STARVE_LIMIT instance plus a STARVE_LIMIT=0 instance.
module tb_n2_tlb_ctl_arb;

    logic       l2clk = 1'b0;
    logic       reset, cam_req, fill_req, fill_index_vld, asi_req, asi_rd, dmp_req;
    logic       tlb_cam_hit, tlb_cam_mhit;
    logic [6:0] fill_index, asi_index;
    logic [1:0] dmp_type;

    logic       cam_stall, fill_gnt, asi_gnt, asi_rd_done, dmp_gnt, dmp_done;
    logic       tlb_cam_vld, tlb_wr_vld, tlb_rd_vld, tlb_rw_index_vld;
    logic       tlb_demap, tlb_demap_context, tlb_demap_all, tlb_demap_real, busy;
    logic [6:0] tlb_rw_index, repl_ptr;

    logic       b_cam_stall, b_fill_gnt, b_asi_gnt, b_asi_rd_done, b_dmp_gnt, b_dmp_done;
    logic       b_tlb_cam_vld, b_tlb_wr_vld, b_tlb_rd_vld, b_tlb_rw_index_vld;
    logic       b_tlb_demap, b_tlb_demap_context, b_tlb_demap_all, b_tlb_demap_real, b_busy;
    logic [6:0] b_tlb_rw_index, b_repl_ptr;
`ifdef N2_TLB_CTL_PERF_EN
    logic [15:0] cam_lookup_cnt, cam_hit_cnt, cam_mhit_cnt;
    logic [15:0] b_cam_lookup_cnt, b_cam_hit_cnt, b_cam_mhit_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 l2clk = ~l2clk;

    n2_tlb_ctl_arb dut (
        .l2clk(l2clk), .reset(reset), .cam_req(cam_req), .cam_stall(cam_stall),
        .fill_req(fill_req), .fill_index_vld(fill_index_vld), .fill_index(fill_index),
        .fill_gnt(fill_gnt), .asi_req(asi_req), .asi_rd(asi_rd), .asi_index(asi_index),
        .asi_gnt(asi_gnt), .asi_rd_done(asi_rd_done), .dmp_req(dmp_req), .dmp_type(dmp_type),
        .dmp_gnt(dmp_gnt), .dmp_done(dmp_done), .tlb_cam_hit(tlb_cam_hit),
        .tlb_cam_mhit(tlb_cam_mhit), .tlb_cam_vld(tlb_cam_vld), .tlb_wr_vld(tlb_wr_vld),
        .tlb_rd_vld(tlb_rd_vld), .tlb_rw_index(tlb_rw_index),
        .tlb_rw_index_vld(tlb_rw_index_vld), .tlb_demap(tlb_demap),
        .tlb_demap_context(tlb_demap_context), .tlb_demap_all(tlb_demap_all),
        .tlb_demap_real(tlb_demap_real), .repl_ptr(repl_ptr), .busy(busy)
`ifdef N2_TLB_CTL_PERF_EN
        , .cam_lookup_cnt(cam_lookup_cnt), .cam_hit_cnt(cam_hit_cnt), .cam_mhit_cnt(cam_mhit_cnt)
`endif
    );

    n2_tlb_ctl_arb #(.STARVE_LIMIT(0)) dut_b (
        .l2clk(l2clk), .reset(reset), .cam_req(cam_req), .cam_stall(b_cam_stall),
        .fill_req(fill_req), .fill_index_vld(fill_index_vld), .fill_index(fill_index),
        .fill_gnt(b_fill_gnt), .asi_req(asi_req), .asi_rd(asi_rd), .asi_index(asi_index),
        .asi_gnt(b_asi_gnt), .asi_rd_done(b_asi_rd_done), .dmp_req(dmp_req), .dmp_type(dmp_type),
        .dmp_gnt(b_dmp_gnt), .dmp_done(b_dmp_done), .tlb_cam_hit(tlb_cam_hit),
        .tlb_cam_mhit(tlb_cam_mhit), .tlb_cam_vld(b_tlb_cam_vld), .tlb_wr_vld(b_tlb_wr_vld),
        .tlb_rd_vld(b_tlb_rd_vld), .tlb_rw_index(b_tlb_rw_index),
        .tlb_rw_index_vld(b_tlb_rw_index_vld), .tlb_demap(b_tlb_demap),
        .tlb_demap_context(b_tlb_demap_context), .tlb_demap_all(b_tlb_demap_all),
        .tlb_demap_real(b_tlb_demap_real), .repl_ptr(b_repl_ptr), .busy(b_busy)
`ifdef N2_TLB_CTL_PERF_EN
        , .cam_lookup_cnt(b_cam_lookup_cnt), .cam_hit_cnt(b_cam_hit_cnt), .cam_mhit_cnt(b_cam_mhit_cnt)
`endif
    );

    // Advance to just after the next rising edge; inputs are driven here, outputs checked #1 later.
    task automatic step();
        @(posedge l2clk);
        #2;
    endtask

    task automatic test_reset();
        step();
        cam_req = 1'b1; fill_req = 1'b1;
        #1;
        n_chk++; if (cam_stall !== 1'b1) $display("FAIL rst_cam_stall got %0b exp 1", cam_stall); else n_pass++;
        n_chk++; if (tlb_cam_vld !== 1'b0) $display("FAIL rst_cam_vld got %0b exp 0", tlb_cam_vld); else n_pass++;
        n_chk++; if (fill_gnt !== 1'b0) $display("FAIL rst_fill_gnt got %0b exp 0", fill_gnt); else n_pass++;
        n_chk++; if (repl_ptr !== 7'd0) $display("FAIL rst_repl_ptr got %0d exp 0", repl_ptr); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        reset = 1'b0; cam_req = 1'b0; fill_req = 1'b0;
        step(); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL post_rst_busy got %0b exp 0", busy); else n_pass++;
    endtask

    task automatic test_fill_repl();
        for (int i = 0; i < 3; i++) begin
            step(); fill_req = 1'b1; fill_index_vld = 1'b0; #1;
            n_chk++; if (fill_gnt !== 1'b1) $display("FAIL fill_gnt[%0d] got %0b exp 1", i, fill_gnt); else n_pass++;
            step(); fill_req = 1'b0; #1;
            n_chk++; if ({tlb_wr_vld, tlb_rw_index_vld} !== 2'b11) $display("FAIL fill_wr_vld[%0d] got %b exp 11", i, {tlb_wr_vld, tlb_rw_index_vld}); else n_pass++;
            n_chk++; if (tlb_rw_index !== 7'(i)) $display("FAIL fill_idx[%0d] got %0d exp %0d", i, tlb_rw_index, i); else n_pass++;
        end
        step(); #1;
        n_chk++; if (repl_ptr !== 7'd3) $display("FAIL repl_ptr3 got %0d exp 3", repl_ptr); else n_pass++;
        fill_req = 1'b1; fill_index_vld = 1'b1; fill_index = 7'h40; #1;
        n_chk++; if (fill_gnt !== 1'b1) $display("FAIL xfill_gnt got %0b exp 1", fill_gnt); else n_pass++;
        step(); fill_req = 1'b0; #1;
        n_chk++; if (tlb_rw_index !== 7'h40) $display("FAIL xfill_idx got %0h exp 40", tlb_rw_index); else n_pass++;
        step(); #1;
        n_chk++; if (repl_ptr !== 7'd3) $display("FAIL xfill_repl got %0d exp 3", repl_ptr); else n_pass++;
        fill_index_vld = 1'b0;
    endtask

    task automatic test_fill_wrap();
        for (int i = 3; i < 127; i++) begin
            step(); fill_req = 1'b1;
            step(); fill_req = 1'b0;
        end
        step(); #1;
        n_chk++; if (repl_ptr !== 7'd127) $display("FAIL repl_ptr127 got %0d exp 127", repl_ptr); else n_pass++;
        fill_req = 1'b1;
        step(); fill_req = 1'b0; #1;
        n_chk++; if (tlb_wr_vld !== 1'b1 || tlb_rw_index !== 7'd127) $display("FAIL wrap_idx got %0d/%0b exp 127/1", tlb_rw_index, tlb_wr_vld); else n_pass++;
        step(); #1;
        n_chk++; if (repl_ptr !== 7'd0) $display("FAIL wrap_repl got %0d exp 0", repl_ptr); else n_pass++;
    endtask

    task automatic test_starve();
        int n_cam = 0;
        logic got = 1'b0;
        step();
        cam_req = 1'b1; asi_req = 1'b1; asi_rd = 1'b1; asi_index = 7'h15;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tlb_cam_vld === 1'b1) n_cam++;
            if (asi_gnt === 1'b1) begin got = 1'b1; break; end
            step();
        end
        n_chk++; if (got !== 1'b1) $display("FAIL starve_gnt got %0b exp 1", got); else n_pass++;
        n_chk++; if (n_cam != 8) $display("FAIL starve_cam_issues got %0d exp 8", n_cam); else n_pass++;
        n_chk++; if (cam_stall !== 1'b1) $display("FAIL starve_stall got %0b exp 1", cam_stall); else n_pass++;
        step(); asi_req = 1'b0; #1;
        n_chk++; if (tlb_rd_vld !== 1'b1 || tlb_rw_index !== 7'h15) $display("FAIL rd_strobe got %0b/%0h exp 1/15", tlb_rd_vld, tlb_rw_index); else n_pass++;
        n_chk++; if (cam_stall !== 1'b1 || tlb_cam_vld !== 1'b0) $display("FAIL rd_cam got %0b/%0b exp 1/0", cam_stall, tlb_cam_vld); else n_pass++;
        step(); #1;
        n_chk++; if (asi_rd_done !== 1'b1 || tlb_rd_vld !== 1'b0) $display("FAIL rd_done got %0b/%0b exp 1/0", asi_rd_done, tlb_rd_vld); else n_pass++;
        step(); #1;
        n_chk++; if (busy !== 1'b0 || tlb_cam_vld !== 1'b1 || asi_rd_done !== 1'b0) $display("FAIL rd_idle got %0b%0b%0b exp 010", busy, tlb_cam_vld, asi_rd_done); else n_pass++;
        cam_req = 1'b0;
    endtask

    task automatic test_demap_priority();
        step();
        dmp_req = 1'b1; dmp_type = 2'd1;
        fill_req = 1'b1; fill_index_vld = 1'b1; fill_index = 7'h22;
        asi_req = 1'b1; asi_rd = 1'b0; asi_index = 7'h33;
        #1;
        n_chk++; if ({dmp_gnt, fill_gnt, asi_gnt} !== 3'b100) $display("FAIL prio_gnt got %b exp 100", {dmp_gnt, fill_gnt, asi_gnt}); else n_pass++;
        step(); dmp_req = 1'b0; #1;
        n_chk++; if ({tlb_demap, tlb_demap_context, tlb_demap_all, tlb_demap_real} !== 4'b1100) $display("FAIL dmp_strobe got %b exp 1100", {tlb_demap, tlb_demap_context, tlb_demap_all, tlb_demap_real}); else n_pass++;
        n_chk++; if (fill_gnt !== 1'b0) $display("FAIL dmp_fill_gnt got %0b exp 0", fill_gnt); else n_pass++;
        step(); #1;
        n_chk++; if (dmp_done !== 1'b1 || tlb_demap !== 1'b0) $display("FAIL dmp_done got %0b/%0b exp 1/0", dmp_done, tlb_demap); else n_pass++;
        step(); #1;
        n_chk++; if ({fill_gnt, asi_gnt} !== 2'b10) $display("FAIL prio_fill got %b exp 10", {fill_gnt, asi_gnt}); else n_pass++;
        step(); fill_req = 1'b0; #1;
        n_chk++; if (tlb_wr_vld !== 1'b1 || tlb_rw_index !== 7'h22) $display("FAIL prio_fill_wr got %0b/%0h exp 1/22", tlb_wr_vld, tlb_rw_index); else n_pass++;
        step(); #1;
        n_chk++; if (asi_gnt !== 1'b1) $display("FAIL prio_asi got %0b exp 1", asi_gnt); else n_pass++;
        step(); asi_req = 1'b0; #1;
        n_chk++; if (tlb_wr_vld !== 1'b1 || tlb_rd_vld !== 1'b0 || tlb_rw_index !== 7'h33) $display("FAIL asi_wr got %0b%0b/%0h exp 10/33", tlb_wr_vld, tlb_rd_vld, tlb_rw_index); else n_pass++;
        step(); #1;
        n_chk++; if (busy !== 1'b0 || repl_ptr !== 7'd0) $display("FAIL prio_end got %0b/%0d exp 0/0", busy, repl_ptr); else n_pass++;
        fill_index_vld = 1'b0;
    endtask

    task automatic test_reset_mid_rd();
        step(); fill_req = 1'b1;
        step(); fill_req = 1'b0;
        step(); #1;
        n_chk++; if (repl_ptr !== 7'd1) $display("FAIL mid_repl got %0d exp 1", repl_ptr); else n_pass++;
        asi_req = 1'b1; asi_rd = 1'b1; asi_index = 7'h05; #1;
        n_chk++; if (asi_gnt !== 1'b1) $display("FAIL mid_gnt got %0b exp 1", asi_gnt); else n_pass++;
        step(); asi_req = 1'b0; #1;
        n_chk++; if (tlb_rd_vld !== 1'b1) $display("FAIL mid_rd got %0b exp 1", tlb_rd_vld); else n_pass++;
        reset = 1'b1;
        step(); #1;
        n_chk++; if ({busy, asi_rd_done, tlb_rd_vld, tlb_wr_vld, cam_stall} !== 5'b00001) $display("FAIL mid_rst got %b exp 00001", {busy, asi_rd_done, tlb_rd_vld, tlb_wr_vld, cam_stall}); else n_pass++;
        n_chk++; if (repl_ptr !== 7'd0) $display("FAIL mid_rst_repl got %0d exp 0", repl_ptr); else n_pass++;
        reset = 1'b0;
        step(); #1;
        n_chk++; if (asi_rd_done !== 1'b0 || busy !== 1'b0) $display("FAIL mid_no_done got %0b/%0b exp 0/0", asi_rd_done, busy); else n_pass++;
        asi_req = 1'b1; #1;
        n_chk++; if (asi_gnt !== 1'b1) $display("FAIL reissue_gnt got %0b exp 1", asi_gnt); else n_pass++;
        step(); asi_req = 1'b0; #1;
        n_chk++; if (tlb_rd_vld !== 1'b1 || tlb_rw_index !== 7'h05) $display("FAIL reissue_rd got %0b/%0h exp 1/05", tlb_rd_vld, tlb_rw_index); else n_pass++;
        step(); #1;
        n_chk++; if (asi_rd_done !== 1'b1) $display("FAIL reissue_done got %0b exp 1", asi_rd_done); else n_pass++;
        step();
    endtask

    task automatic test_starve_zero();
        step();
        cam_req = 1'b1; fill_req = 1'b1; fill_index_vld = 1'b0; #1;
        n_chk++; if ({b_fill_gnt, b_cam_stall, b_tlb_cam_vld} !== 3'b110) $display("FAIL lim0_gnt got %b exp 110", {b_fill_gnt, b_cam_stall, b_tlb_cam_vld}); else n_pass++;
        step(); fill_req = 1'b0; #1;
        n_chk++; if ({b_tlb_wr_vld, b_cam_stall, b_tlb_cam_vld} !== 3'b110) $display("FAIL lim0_wr got %b exp 110", {b_tlb_wr_vld, b_cam_stall, b_tlb_cam_vld}); else n_pass++;
        step(); #1;
        n_chk++; if ({b_tlb_cam_vld, b_cam_stall} !== 2'b10) $display("FAIL lim0_cam got %b exp 10", {b_tlb_cam_vld, b_cam_stall}); else n_pass++;
        cam_req = 1'b0;
    endtask

`ifdef N2_TLB_CTL_PERF_EN
    task automatic test_perf();
        step(); reset = 1'b1;
        step(); reset = 1'b0; cam_req = 1'b1; tlb_cam_hit = 1'b1; tlb_cam_mhit = 1'b0;
        repeat (70000) step();
        cam_req = 1'b0;
        step(); step(); #1;
        n_chk++; if (cam_lookup_cnt !== 16'hFFFF) $display("FAIL perf_lookup got %0h exp ffff", cam_lookup_cnt); else n_pass++;
        n_chk++; if (cam_hit_cnt !== 16'hFFFF) $display("FAIL perf_hit got %0h exp ffff", cam_hit_cnt); else n_pass++;
        n_chk++; if (cam_mhit_cnt !== 16'h0000) $display("FAIL perf_mhit got %0h exp 0", cam_mhit_cnt); else n_pass++;
        tlb_cam_hit = 1'b0;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cam_req = 1'b0; fill_req = 1'b0; fill_index_vld = 1'b0; fill_index = 7'd0;
        asi_req = 1'b0; asi_rd = 1'b0; asi_index = 7'd0; dmp_req = 1'b0; dmp_type = 2'd0;
        tlb_cam_hit = 1'b0; tlb_cam_mhit = 1'b0;
        test_reset();
        test_fill_repl();
        test_fill_wrap();
        test_starve();
        test_demap_priority();
        test_reset_mid_rd();
        test_starve_zero();
`ifdef N2_TLB_CTL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/n2_tlb_ctl_arb.md
Name: n2_tlb_ctl_arb

Overview:
Control sequencer and arbiter for the 128-entry TLB array. It shares the array's single port among four requesters:
- the pipeline CAM lookup
- the MMU tablewalk fill write
- the ASI diagnostic read/write
- demap
It issues exactly one array operation per cycle, generates the tlb_* control strobes, owns the fill replacement pointer, and prevents maintenance operations from being starved by back-to-back lookups.

Parameters:
STARVE_LIMIT, 8, consecutive CAM grants allowed while a maintenance request waits; 0 means maintenance always wins.
IDX_W, 7, array index width (128 entries).

Ports:
l2clk  in  1  clock
reset  in  1  synchronous, active-high reset
cam_req  in  1  pipeline lookup request, this cycle
cam_stall  out  1  lookup not issued this cycle; pipeline must replay
fill_req  in  1  tablewalk fill write request, held until granted
fill_index_vld  in  1  fill_index is valid; 0 selects the replacement pointer
fill_index  in  7  explicit fill index
fill_gnt  out  1  fill accepted, one-cycle pulse
asi_req  in  1  ASI access request, held until granted
asi_rd  in  1  1 = read, 0 = write
asi_index  in  7  ASI entry index
asi_gnt  out  1  ASI access accepted, pulse
asi_rd_done  out  1  read data is valid on the array's tte outputs, pulse
dmp_req  in  1  demap request, held until granted
dmp_type  in  2  0 = page, 1 = context, 2 = all, 3 = real
dmp_gnt  out  1  demap accepted, pulse
dmp_done  out  1  demap complete, pulse
tlb_cam_hit  in  1  array hit (perf only)
tlb_cam_mhit  in  1  array multi-hit (perf only)
tlb_cam_vld  out  1  array CAM strobe
tlb_wr_vld  out  1  array write strobe
tlb_rd_vld  out  1  array read strobe
tlb_rw_index  out  7  array read/write index
tlb_rw_index_vld  out  1  asserted with every wr/rd strobe
tlb_demap  out  1  demap strobe
tlb_demap_context  out  1  demap qualifier
tlb_demap_all  out  1  demap qualifier
tlb_demap_real  out  1  demap qualifier
repl_ptr  out  7  current replacement pointer
busy  out  1  state is not IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, repl_ptr=0, starve_cnt=0.
  - All strobes, grants and done pulses are 0; cam_stall=1 while reset is asserted.
- States: IDLE, WR, RD, RD_WAIT, DMP, DMP_WAIT.
- maint_pend = fill_req | asi_req | dmp_req.
- In IDLE:
  - Maintenance is selected when maint_pend and (!cam_req or starve_cnt==STARVE_LIMIT).
  - Otherwise a pending cam_req is issued: tlb_cam_vld=1, cam_stall=0, same cycle (combinational).
- Maintenance priority is fixed: demap > fill > ASI. The winner's gnt pulses in the selection cycle, and cam_stall=1 in that cycle.
- Next state after a grant:
  - fill → WR
  - ASI write → WR
  - ASI read → RD
  - demap → DMP
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each CAM issue while maint_pend.
  - Clears on any maintenance grant, and when !maint_pend.
- WR (1 cycle): tlb_wr_vld=1, tlb_rw_index_vld=1, then → IDLE. The index is registered at grant:
  - fill with index_vld=1 → fill_index
  - fill with index_vld=0 → repl_ptr
  - ASI write → asi_index
- repl_ptr: increments by 1 mod 128 after each fill that used it (127 → 0). It is unchanged by explicit-index fills and by ASI writes.
- RD: tlb_rd_vld=1, tlb_rw_index_vld=1 for 1 cycle → RD_WAIT. RD_WAIT asserts asi_rd_done=1 for 1 cycle → IDLE. Read latency from grant to done is 2 cycles.
- DMP: tlb_demap=1 plus the one qualifier decoded from the registered dmp_type (page asserts no qualifier), for 1 cycle → DMP_WAIT. DMP_WAIT asserts dmp_done=1 → IDLE.
- In every non-IDLE state: cam_stall=cam_req and tlb_cam_vld=0. There are no back-to-back maintenance ops; IDLE always intervenes, so the array is never driven by two strobes in one cycle.
- The first maintenance grant can occur in the IDLE cycle that follows an op state.
- Requests that deassert before grant are dropped, with no error.
- Reset mid-operation: return to IDLE next cycle. No done pulse is issued for the aborted op and repl_ptr returns to 0; the requester must re-request.

Optional Feature:
N2_TLB_CTL_PERF_EN
- Defined: three 16-bit saturating counters, each cleared by reset:
  - cam_lookup_cnt: increments on tlb_cam_vld.
  - cam_hit_cnt: increments when tlb_cam_hit is sampled one cycle after tlb_cam_vld.
  - cam_mhit_cnt: increments when tlb_cam_mhit is sampled one cycle after tlb_cam_vld.
  The counters are exported as extra outputs. In this build only, tlb_cam_hit and tlb_cam_mhit are functional.
- Undefined: no counters, the extra ports are absent, and the hit inputs are unused.

Decomposition:
- Package n2_tlb_ctl_pkg holds: the state enum; the dmp_type encodings; IDX_W; the default STARVE_LIMIT; the perf counter width.
- One sub-module, n2_tlb_ctl_perf, holds the counters and is instantiated only under N2_TLB_CTL_PERF_EN.

Test Plan:
- Reset, then fill_req with index_vld=0 three times → tlb_wr_vld at idx 0, 1, 2; repl_ptr=3. Preload repl_ptr=127 and fill → write at 127, repl_ptr=0.
- Continuous cam_req with asi_req (read, idx 0x15) raised, STARVE_LIMIT=8 → 8 CAM issues, then asi_gnt with cam_stall=1. tlb_rd_vld idx 0x15 follows; asi_rd_done comes 2 cycles after grant.
- dmp_req (type=1), fill_req and asi_req raised in the same cycle → dmp_gnt first; tlb_demap + tlb_demap_context for 1 cycle; dmp_done; then fill, then ASI, with an IDLE cycle between each.
- Reset asserted in RD state → no asi_rd_done, all strobes 0, state IDLE next cycle; re-issued read completes normally.
- STARVE_LIMIT=0 with cam_req and fill_req held → fill granted immediately; cam_stall=1 for grant + WR cycles.
- PERF_EN: 70000 lookups with hit=1 → cam_lookup_cnt and cam_hit_cnt saturate at 0xFFFF.
